// File: rtl/lcd_pkg.sv
// Shared timing defaults, RGB565 layout and colour-bar table for the LCD timing generator.
// Colour bars exist only when LCD_TEST_PATTERN_EN is defined.
package lcd_pkg;

  localparam int DEF_H_ACTIVE = 800;
  localparam int DEF_H_FP     = 40;
  localparam int DEF_H_SYNC   = 128;
  localparam int DEF_H_BP     = 88;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 13;
  localparam int DEF_V_SYNC   = 3;
  localparam int DEF_V_BP     = 29;

  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  typedef enum logic [1:0] {
    RGN_ACTIVE,
    RGN_FP,
    RGN_SYNC,
    RGN_BP
  } region_t;

  typedef struct packed {
    logic [R_W-1:0] r;
    logic [G_W-1:0] g;
    logic [B_W-1:0] b;
  } rgb565_t;

  // White, yellow, cyan, green, magenta, red, blue, black.
  localparam int N_BARS = 8;
  localparam logic [RGB_W-1:0] BAR_RGB [N_BARS] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  function automatic rgb565_t to_rgb565(input logic [RGB_W-1:0] raw);
    return rgb565_t'(raw);
  endfunction

endpackage

// File: rtl/lcd_sync_counter.sv
// One timing axis: a wrapping counter with active / front porch / sync / back porch decode.
// Used once per pixel (horizontal) and once per line (vertical).
module lcd_sync_counter
  import lcd_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = $clog2(ACTIVE + FP + SYNC + BP)
) (
  input  logic         pclk,
  input  logic         SYS_RSTn,
  input  logic         run,
  input  logic         en,
  output logic [W-1:0] count_next,
  output logic         last,
  output logic         active,
  output logic         sync
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST_C     = W'(TOTAL - 1);
  localparam logic [W-1:0] FP_START   = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
  localparam logic [W-1:0] BP_START   = W'(ACTIVE + FP + SYNC);

  logic [W-1:0] count;
  region_t      region;

  assign last = (count == LAST_C);

  // Held at zero until the top starts running, so the first live cycle is position 0.
  always_comb begin
    // NOTE: default assignment first keeps this always_comb free of inferred latches.
    count_next = count;
    if (!run)    count_next = '0;
    else if (en) count_next = last ? '0 : count + W'(1);
  end

  always_ff @(posedge pclk) begin
    if (!SYS_RSTn) count <= '0;
    else           count <= count_next;
  end

  always_comb begin
    region = RGN_BP;
    if (count < FP_START)        region = RGN_ACTIVE;
    else if (count < SYNC_START) region = RGN_FP;
    else if (count < BP_START)   region = RGN_SYNC;
  end

  assign active = (region == RGN_ACTIVE);
  assign sync   = (region == RGN_SYNC);

endmodule

// File: rtl/lcd_timing.sv
// RGB565 LCD timing generator: H/V counters, registered sync/den/colour, underrun fill.
// Define LCD_TEST_PATTERN_EN to add the test_mode port and 8-bar colour pattern.
module lcd_timing
  import lcd_pkg::*;
#(
  parameter int               H_ACTIVE = DEF_H_ACTIVE,
  parameter int               H_FP     = DEF_H_FP,
  parameter int               H_SYNC   = DEF_H_SYNC,
  parameter int               H_BP     = DEF_H_BP,
  parameter int               V_ACTIVE = DEF_V_ACTIVE,
  parameter int               V_FP     = DEF_V_FP,
  parameter int               V_SYNC   = DEF_V_SYNC,
  parameter int               V_BP     = DEF_V_BP,
  parameter logic [RGB_W-1:0] FILL_RGB = 16'hFFFF
) (
  input  logic             pclk,
  input  logic             SYS_RSTn,
  input  logic [RGB_W-1:0] pix_data,
  input  logic             pix_valid,
`ifdef LCD_TEST_PATTERN_EN
  input  logic             test_mode,
`endif
  output logic             pix_req,
  output logic             line_start,
  output logic             frame_start,
  output logic [R_W-1:0]   red,
  output logic [G_W-1:0]   green,
  output logic [B_W-1:0]   blue,
  output logic             hsync,
  output logic             vsync,
  output logic             den,
  output logic             underrun
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_LEAD_LIM = VW'(V_ACTIVE - 1);

  logic             run;
  logic [HW-1:0]    h_next;
  logic [VW-1:0]    v_next;
  logic             h_last, v_last;
  logic             h_active, v_active;
  logic             h_sync, v_sync;
  logic             in_active;
  logic             miss;
  logic             und_pend;
  logic [RGB_W-1:0] next_rgb;
  rgb565_t          pix_q;

  lcd_sync_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .W      (HW)
  ) u_h_cnt (
    .pclk       (pclk),
    .SYS_RSTn   (SYS_RSTn),
    .run        (run),
    .en         (1'b1),
    .count_next (h_next),
    .last       (h_last),
    .active     (h_active),
    .sync       (h_sync)
  );

  lcd_sync_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .W      (VW)
  ) u_v_cnt (
    .pclk       (pclk),
    .SYS_RSTn   (SYS_RSTn),
    .run        (run),
    .en         (h_last),
    .count_next (v_next),
    .last       (v_last),
    .active     (v_active),
    .sync       (v_sync)
  );

  assign in_active = run && h_active && v_active;

`ifdef LCD_TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / N_BARS;
  localparam int PXW   = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [PXW-1:0] BAR_LAST = PXW'(BAR_W - 1);

  logic [PXW-1:0] bar_px;
  logic [2:0]     bar_idx;

  // Tracks h / BAR_W incrementally so no divider is needed.
  always_ff @(posedge pclk) begin
    if (!SYS_RSTn || h_next == '0) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (bar_px == BAR_LAST) begin
      bar_px  <= '0;
      bar_idx <= bar_idx + 3'd1;
    end else begin
      bar_px  <= bar_px + PXW'(1);
    end
  end

  assign pix_req = in_active && !test_mode;
`else
  assign pix_req = in_active;
`endif

  assign miss = pix_req && !pix_valid;

  always_comb begin
    next_rgb = '0;
    if (in_active) next_rgb = pix_valid ? pix_data : FILL_RGB;
`ifdef LCD_TEST_PATTERN_EN
    if (in_active && test_mode) next_rgb = BAR_RGB[bar_idx];
`endif
  end

  // frame_start/line_start are decoded from the next counter state so they
  // coincide with h=0; den/sync/colour lag the counters by one pclk.
  always_ff @(posedge pclk) begin
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    if (!SYS_RSTn) begin
      run         <= 1'b0;
      den         <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      pix_q       <= '0;
    end else begin
      run         <= 1'b1;
      den         <= in_active;
      hsync       <= run && h_sync;
      vsync       <= run && v_sync;
      frame_start <= !run || (h_last && v_last);
      line_start  <= (h_next == '0) && ((v_next == V_LAST) || (v_next < V_LEAD_LIM));
      pix_q       <= to_rgb565(next_rgb);
    end
  end

  // Clear on frame_start wins; a miss in that same cycle is replayed one cycle later.
  always_ff @(posedge pclk) begin
    if (!SYS_RSTn) begin
      underrun <= 1'b0;
      und_pend <= 1'b0;
    end else if (frame_start) begin
      underrun <= 1'b0;
      und_pend <= miss;
    end else begin
      if (miss || und_pend) underrun <= 1'b1;
      und_pend <= 1'b0;
    end
  end

  assign red   = pix_q.r;
  assign green = pix_q.g;
  assign blue  = pix_q.b;

endmodule

// File: tb/tb_lcd_timing.sv
// Directed bench for lcd_timing using a reduced raster (48 x 15) to keep frames short.
// Expected values are hand-derived from the reduced timing constants below.
module tb_lcd_timing;

  localparam int HA = 32, HF = 4, HS = 8, HB = 4;   // line total 48
  localparam int VA = 8,  VF = 2, VS = 3, VB = 2;   // frame total 15 lines
  localparam int FRAME = 720;
  localparam logic [15:0] FILL = 16'hFFFF;
  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

  logic        pclk = 1'b0;
  logic        SYS_RSTn;
  logic [15:0] pix_data;
  logic        pix_valid;
  logic        test_mode;
  logic        pix_req, line_start, frame_start;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        hsync, vsync, den, underrun;

  always #5 pclk = ~pclk;

  lcd_timing #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .FILL_RGB (FILL)
  ) dut (
    .pclk        (pclk),
    .SYS_RSTn    (SYS_RSTn),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
`ifdef LCD_TEST_PATTERN_EN
    .test_mode   (test_mode),
`endif
    .pix_req     (pix_req),
    .line_start  (line_start),
    .frame_start (frame_start),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync),
    .den         (den),
    .underrun    (underrun)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Per-window statistics gathered by scan().
  int den_cnt, den_runs, den_bad, den_len, first_den;
  int hs_cnt, hs_runs, hs_bad, hs_len;
  int vs_cnt, vs_rise;
  int ls_cnt, ls_probe, ls_hit;
  int fs_cnt, und_cnt, und_first, preq_cnt;
  int exp_hits, fill_hits, first_fill, bad_col;
  int drop_from, drop_to;
  logic [15:0] first_rgb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pclk);
    cyc++;
  endtask

  task automatic scan(input int n, input logic [15:0] exp_rgb);
    logic p_den, p_hs, p_vs;
    logic [15:0] rgb;
    den_cnt = 0; den_runs = 0; den_bad = 0; den_len = 0; first_den = -1;
    hs_cnt = 0; hs_runs = 0; hs_bad = 0; hs_len = 0;
    vs_cnt = 0; vs_rise = -1; ls_cnt = 0; ls_hit = 0; fs_cnt = 0;
    und_cnt = 0; und_first = -1; preq_cnt = 0;
    exp_hits = 0; fill_hits = 0; first_fill = -1; bad_col = 0;
    first_rgb = '0;
    p_den = den; p_hs = hsync; p_vs = vsync;
    for (int i = 0; i < n; i++) begin
      tick();
      rgb = {red, green, blue};
      if (den) begin
        den_cnt++;
        den_len = p_den ? den_len + 1 : 1;
        if (!p_den) begin
          den_runs++;
          if (first_den < 0) begin first_den = cyc; first_rgb = rgb; end
        end
        if (rgb === exp_rgb) exp_hits++;
        else if (rgb === FILL) begin
          fill_hits++;
          if (first_fill < 0) first_fill = cyc;
        end else bad_col++;
      end else begin
        if (p_den && den_len != HA) den_bad++;
        if (rgb !== 16'h0000) bad_col++;
      end
      if (hsync) begin
        hs_cnt++;
        hs_len = p_hs ? hs_len + 1 : 1;
        if (!p_hs) hs_runs++;
      end else if (p_hs && hs_len != HS) hs_bad++;
      if (vsync) begin
        vs_cnt++;
        if (!p_vs && vs_rise < 0) vs_rise = cyc;
      end
      if (line_start) begin
        ls_cnt++;
        if (cyc == ls_probe) ls_hit = 1;
      end
      if (frame_start) fs_cnt++;
      if (underrun) begin
        und_cnt++;
        if (und_first < 0) und_first = cyc;
      end
      if (pix_req) preq_cnt++;
      p_den = den; p_hs = hsync; p_vs = vsync;
      pix_valid = !(cyc >= drop_from && cyc <= drop_to);
    end
  endtask

  initial begin
    int bad, first_ok, last_ok, preq, und;
    SYS_RSTn  = 1'b0;
    pix_valid = 1'b1;
    pix_data  = 16'hF800;
    test_mode = 1'b0;
    drop_from = -1;
    drop_to   = -1;
    ls_probe  = -1;

    repeat (3) @(negedge pclk);
    check("reset_outputs",
          {den, hsync, vsync, frame_start, line_start, underrun, pix_req, red, green, blue}, 32'd0);

    // Release; cycle numbering counts pclk periods after the release point.
    SYS_RSTn = 1'b1;
    cyc = 0;
    tick();
    check("cyc1_frame_start", frame_start, 1);
    check("cyc1_den", den, 0);
    check("cyc1_pix_req", pix_req, 1);
    check("cyc1_line_start", line_start, 1);

    // Frame 0 outputs occupy cycles 2..721.
    ls_probe = 1 + 14 * 48;
    scan(FRAME, 16'hF800);
    check("first_den_cycle", first_den, 2);
    check("first_red", first_rgb[15:11], 31);
    check("first_green", first_rgb[10:5], 0);
    check("first_blue", first_rgb[4:0], 0);
    check("den_cycles_frame", den_cnt, VA * HA);
    check("den_lines_frame", den_runs, VA);
    check("den_bad_runs", den_bad, 0);
    check("colour_f800_hits", exp_hits, VA * HA);
    check("colour_bad", bad_col, 0);
    check("hsync_cycles", hs_cnt, 15 * HS);
    check("hsync_lines", hs_runs, 15);
    check("hsync_bad_runs", hs_bad, 0);
    check("vsync_cycles", vs_cnt, 3 * 48);
    check("vsync_rise", vs_rise, 2 + 10 * 48);
    check("line_start_count", ls_cnt, 8);
    check("line_start_lead_v0", ls_hit, 1);
    check("pix_req_count", preq_cnt, VA * HA);
    check("frame_start_period", fs_cnt, 1);
    check("frame_start_721", frame_start, 1);
    check("underrun_clean", und_cnt, 0);

    // Frame 1: pixels h=10..14 of line 2 are missing.
    drop_from = 721 + 2 * 48 + 10;
    drop_to   = drop_from + 4;
    ls_probe  = -1;
    scan(FRAME, 16'hF800);
    check("ur_den_cycles", den_cnt, VA * HA);
    check("ur_den_lines", den_runs, VA);
    check("ur_den_bad_runs", den_bad, 0);
    check("ur_fill_pixels", fill_hits, 5);
    check("ur_first_fill", first_fill, 828);
    check("ur_data_pixels", exp_hits, VA * HA - 5);
    check("ur_colour_bad", bad_col, 0);
    check("ur_first_set", und_first, 828);
    check("ur_sticky_cycles", und_cnt, 1441 - 828 + 1);
    check("ur_frame_start", frame_start, 1);
    tick();
    check("ur_cleared", underrun, 0);

    // Reset pulse with counter state h=16, v=4 of the frame starting at 1441.
    while (cyc < 1649) tick();
    check("pre_reset_den", den, 1);
    SYS_RSTn = 1'b0;
    tick();
    check("midreset_outputs",
          {den, hsync, vsync, frame_start, line_start, underrun, pix_req, red, green, blue}, 32'd0);
    SYS_RSTn = 1'b1;
    tick();
    check("restart_frame_start", frame_start, 1);
    check("restart_den_low", den, 0);
    tick();
    check("restart_den_rise", den, 1);
    while (!frame_start && cyc < 1652 + 2 * FRAME) tick();
    check("restart_next_frame", cyc, 1651 + FRAME);

`ifdef LCD_TEST_PATTERN_EN
    // Colour bars, 4 pixels wide here; upstream deliberately starved.
    test_mode = 1'b1;
    pix_valid = 1'b0;
    bad = 0; first_ok = 0; last_ok = 0; preq = 0; und = 0;
    for (int i = 0; i < HA; i++) begin
      tick();
      if (!den || {red, green, blue} !== BARS[i / 4]) bad++;
      if (i < 4 && den && {red, green, blue} === 16'hFFFF) first_ok++;
      if (i >= 28 && den && {red, green, blue} === 16'h0000) last_ok++;
      if (pix_req) preq++;
      if (underrun) und++;
    end
    for (int i = 0; i < 2 * FRAME && !frame_start; i++) begin
      tick();
      if (pix_req) preq++;
      if (underrun) und++;
    end
    check("tp_bar_line", bad, 0);
    check("tp_first_bar_white", first_ok, 4);
    check("tp_last_bar_black", last_ok, 4);
    check("tp_pix_req_low", preq, 0);
    check("tp_no_underrun", und, 0);
    check("tp_next_frame", frame_start, 1);
    test_mode = 1'b0;
    pix_valid = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
